// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with a two-slot skid buffer. Upstream ready comes only from
// registered state, and a saturating counter tracks cycles of execute back-pressure.
module id_ex_pipe #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CTRL_WIDTH     = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      id_valid_i,
  output logic                      id_ready_o,
  input  logic [DATA_WIDTH-1:0]     id_pc_i,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     id_imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
  input  logic [CTRL_WIDTH-1:0]     id_ctrl_i,
  input  logic                      flush_i,
  input  logic                      clr_cnt_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output logic [DATA_WIDTH-1:0]     ex_pc_o,
  output logic [DATA_WIDTH-1:0]     ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0]     ex_rs2_data_o,
  output logic [DATA_WIDTH-1:0]     ex_imm_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_o,
  output logic [CTRL_WIDTH-1:0]     ex_ctrl_o,
  output logic [15:0]               stall_cnt_o
);

  localparam int unsigned PayloadW = 4 * DATA_WIDTH + 3 * REG_ADDR_WIDTH + CTRL_WIDTH;

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StFull  = 2'd1;
  localparam logic [1:0] StSkid  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PayloadW-1:0] main_q, main_d;
  logic [PayloadW-1:0] skid_q, skid_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;
  logic [PayloadW-1:0] in_payload;
  logic                accept, fire;

  assign in_payload = {id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
                       id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ctrl_i};

  assign id_ready_o = (state_q != StSkid);
  assign ex_valid_o = (state_q != StEmpty);
  assign accept     = id_valid_i & id_ready_o & ~flush_i;
  assign fire       = ex_valid_o & ex_ready_i;

  assign {ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
          ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_ctrl_o} = main_q;
  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
          main_d  = in_payload;
        end
      end
      StFull: begin
        if (accept && fire) begin
          main_d = in_payload;
        end else if (accept) begin
          state_d = StSkid;
          skid_d  = in_payload;
        end else if (fire) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (fire) begin
          state_d = StFull;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over any accept/fire; stale payload bits stay but are never marked valid.
    if (flush_i) state_d = StEmpty;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt_i) begin
      stall_cnt_d = 16'd0;
    end else if (ex_valid_o && !ex_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: an occupancy model plus a queue of expected payloads
// checks handshakes, ordering, payload contents, the stall counter and async reset.
module tb_id_ex_pipe;

  localparam int unsigned PW = 4 * 32 + 3 * 5 + 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        id_valid_i, id_ready_o;
  logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [7:0]  id_ctrl_i;
  logic        flush_i, clr_cnt_i;
  logic        ex_valid_o, ex_ready_i;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
  logic [7:0]  ex_ctrl_o;
  logic [15:0] stall_cnt_o;

  int tests = 0;
  int fails = 0;

  logic [PW-1:0] exp_q[$];
  int            occ = 0;
  logic [15:0]   cnt_m = 16'd0;
  logic [PW-1:0] obs_payload;

  always #5 clk = ~clk;

  id_ex_pipe #(
    .DATA_WIDTH    (32),
    .REG_ADDR_WIDTH(5),
    .CTRL_WIDTH    (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .id_valid_i   (id_valid_i),
    .id_ready_o   (id_ready_o),
    .id_pc_i      (id_pc_i),
    .id_rs1_data_i(id_rs1_data_i),
    .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i     (id_imm_i),
    .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i),
    .id_rd_addr_i (id_rd_addr_i),
    .id_ctrl_i    (id_ctrl_i),
    .flush_i      (flush_i),
    .clr_cnt_i    (clr_cnt_i),
    .ex_valid_o   (ex_valid_o),
    .ex_ready_i   (ex_ready_i),
    .ex_pc_o      (ex_pc_o),
    .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o     (ex_imm_o),
    .ex_rs1_addr_o(ex_rs1_addr_o),
    .ex_rs2_addr_o(ex_rs2_addr_o),
    .ex_rd_addr_o (ex_rd_addr_o),
    .ex_ctrl_o    (ex_ctrl_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  assign obs_payload = {ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
                        ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_ctrl_o};

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Derives the remaining payload fields from pc so each instruction is distinct.
  function automatic logic [PW-1:0] mk(input logic [31:0] pc, input logic [31:0] imm,
                                       input logic [7:0] ctrl, input logic [4:0] rd);
    logic [4:0] a1, a2;
    a1 = rd + 5'd1;
    a2 = rd + 5'd2;
    return {pc, {pc[15:0], ~pc[15:0]}, pc * 32'd3, imm, a1, a2, rd, ctrl};
  endfunction

  // One cycle: drive, check pre-edge outputs against the model, advance model, clock.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [7:0] ctrl, input logic [4:0] rd, input logic rdy,
                      input logic fl, input logic clr);
    logic [PW-1:0] p;
    logic          acc, fir;
    p = mk(pc, imm, ctrl, rd);
    id_valid_i = v;
    {id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
     id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ctrl_i} = p;
    ex_ready_i = rdy;
    flush_i    = fl;
    clr_cnt_i  = clr;
    #1;
    check("ex_valid", {159'd0, ex_valid_o}, {159'd0, occ > 0});
    check("id_ready", {159'd0, id_ready_o}, {159'd0, occ < 2});
    if (occ > 0) check("payload", {9'd0, obs_payload}, {9'd0, exp_q[0]});
    acc = v && (occ < 2) && !fl;
    fir = (occ > 0) && rdy;
    if (clr) cnt_m = 16'd0;
    else if ((occ > 0) && !rdy && (cnt_m != 16'hFFFF)) cnt_m = cnt_m + 16'd1;
    if (fir) begin
      void'(exp_q.pop_front());
      occ--;
    end
    if (acc) begin
      exp_q.push_back(p);
      occ++;
    end
    if (fl) begin
      exp_q.delete();
      occ = 0;
    end
    @(posedge clk);
    #1;
    check("stall_cnt", {144'd0, stall_cnt_o}, {144'd0, cnt_m});
  endtask

  task automatic check_reset_outputs();
    check("rst_ex_valid", {159'd0, ex_valid_o}, 160'd0);
    check("rst_id_ready", {159'd0, id_ready_o}, 160'd1);
    check("rst_payload", {9'd0, obs_payload}, 160'd0);
    check("rst_stall_cnt", {144'd0, stall_cnt_o}, 160'd0);
  endtask

  initial begin
    id_valid_i = 1'b0; ex_ready_i = 1'b0; flush_i = 1'b0; clr_cnt_i = 1'b0;
    {id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
     id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ctrl_i} = '0;
    rst_ni = 1'b0;
    #2;
    check_reset_outputs();
    #11 rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full rate
    step(1, 32'h0, 32'h1, 8'h01, 5'd1, 1, 0, 0);
    step(1, 32'h4, 32'h2, 8'h02, 5'd2, 1, 0, 0);
    step(1, 32'h8, 32'h3, 8'h03, 5'd3, 1, 0, 0);
    check("stream_pc", {128'd0, ex_pc_o}, 160'h8);
    step(0, 32'h0, 32'h0, 8'h00, 5'd0, 1, 0, 0);

    // Back-pressure fills the skid slot, then drains in order
    step(1, 32'h10, 32'h10, 8'h10, 5'd4, 0, 0, 0);
    step(1, 32'h14, 32'h14, 8'h14, 5'd5, 0, 0, 0);
    step(1, 32'h18, 32'h18, 8'h18, 5'd6, 0, 0, 0);
    check("bp_hold_pc", {128'd0, ex_pc_o}, 160'h10);
    step(0, 32'h0, 32'h0, 8'h00, 5'd0, 1, 0, 0);
    check("bp_drain_pc", {128'd0, ex_pc_o}, 160'h14);
    step(0, 32'h0, 32'h0, 8'h00, 5'd0, 1, 0, 0);
    step(0, 32'h0, 32'h0, 8'h00, 5'd0, 1, 0, 0);

    // Payload integrity
    step(1, 32'h20, 32'hFFFF_F800, 8'hA5, 5'd31, 1, 0, 0);
    check("imm", {128'd0, ex_imm_o}, {128'd0, 32'hFFFF_F800});
    check("ctrl", {152'd0, ex_ctrl_o}, {152'd0, 8'hA5});
    check("rd", {155'd0, ex_rd_addr_o}, {155'd0, 5'd31});
    step(0, 32'h0, 32'h0, 8'h00, 5'd0, 1, 0, 0);

    // Stall counter: five stalled cycles, clear under stall, then saturation
    step(1, 32'h30, 32'h30, 8'h30, 5'd7, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 32'h0, 8'h00, 5'd0, 0, 0, 0);
    check("cnt_five", {144'd0, stall_cnt_o}, 160'd5);
    step(0, 32'h0, 32'h0, 8'h00, 5'd0, 0, 0, 1);
    check("cnt_clear", {144'd0, stall_cnt_o}, 160'd0);
    id_valid_i = 1'b0; ex_ready_i = 1'b0; clr_cnt_i = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    cnt_m = 16'hFFFF;
    check("cnt_sat", {144'd0, stall_cnt_o}, 160'hFFFF);
    step(0, 32'h0, 32'h0, 8'h00, 5'd0, 0, 0, 0);

    // Flush while both slots are full with a new instruction offered
    step(1, 32'h40, 32'h40, 8'h40, 5'd8, 0, 0, 0);
    step(1, 32'h44, 32'h44, 8'h44, 5'd9, 0, 1, 0);
    check("flush_valid", {159'd0, ex_valid_o}, 160'd0);
    check("flush_ready", {159'd0, id_ready_o}, 160'd1);
    step(1, 32'h50, 32'h50, 8'h50, 5'd10, 1, 0, 0);
    step(0, 32'h0, 32'h0, 8'h00, 5'd0, 1, 0, 0);

    // Async reset between edges while in the skid state
    step(1, 32'h60, 32'h60, 8'h60, 5'd11, 0, 0, 0);
    step(1, 32'h64, 32'h64, 8'h64, 5'd12, 0, 0, 0);
    id_valid_i = 1'b0;
    #3 rst_ni = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    occ = 0;
    cnt_m = 16'd0;
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    step(1, 32'h70, 32'h70, 8'h70, 5'd13, 1, 0, 0);
    check("post_rst_pc", {128'd0, ex_pc_o}, 160'h70);
    step(0, 32'h0, 32'h0, 8'h00, 5'd0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of PC, operand and immediate fields.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register-file address width.
REQ-003 SHALL have parameter CTRL_WIDTH, default 8, opaque decoded-control bundle width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports in REQ-005..006.
REQ-005 clk_i  input  1  clock, all state updates on rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 id_valid_i  input  1  decode stage presents a valid instruction.
REQ-008 id_ready_o  output  1  this block can accept an instruction this cycle.
REQ-009 id_pc_i  input  DATA_WIDTH  instruction PC.
REQ-010 id_rs1_data_i, id_rs2_data_i  input  DATA_WIDTH each  register-file read data.
REQ-011 id_imm_i  input  DATA_WIDTH  extended immediate/shamt/offset from the decode extender.
REQ-012 id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  input  REG_ADDR_WIDTH each  source/destination indices.
REQ-013 id_ctrl_i  input  CTRL_WIDTH  decoded control bundle.
REQ-014 flush_i  input  1  discard all held and incoming instructions.
REQ-015 clr_cnt_i  input  1  synchronous clear of stall counter.
REQ-016 ex_valid_o  output  1  execute-side payload valid.
REQ-017 ex_ready_i  input  1  execute stage accepts payload.
REQ-018 ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_ctrl_o  output  widths as inputs  registered payload.
REQ-019 stall_cnt_o  output  16  saturating count of back-pressure cycles.

Function
REQ-020 Definitions: accept = id_valid_i & id_ready_o & !flush_i; fire = ex_valid_o & ex_ready_i.
REQ-021 Storage SHALL be two payload slots: MAIN (drives ex_* outputs) and SKID.
REQ-022 States SHALL be EMPTY (no slot valid), FULL (MAIN valid), SKID (both valid).
REQ-023 ex_valid_o SHALL be 1 exactly in FULL and SKID.
REQ-024 id_ready_o SHALL be 1 in EMPTY and FULL, 0 in SKID; it SHALL depend only on registered state (no combinational path from ex_ready_i).
REQ-025 EMPTY: accept -> FULL, MAIN <= inputs; else stay.
REQ-026 FULL: accept & fire -> FULL, MAIN <= inputs; accept & !fire -> SKID, SKID <= inputs; !accept & fire -> EMPTY; else hold.
REQ-027 SKID: fire -> FULL, MAIN <= SKID slot; else hold.
REQ-028 flush_i = 1 SHALL force EMPTY next cycle from any state, overriding accept and fire; incoming instruction is dropped.
REQ-029 Latency SHALL be one cycle: instruction accepted at edge N appears on ex_* after edge N when MAIN was empty or firing.
REQ-030 Instruction order SHALL be preserved; no instruction lost or duplicated except by flush.
REQ-031 While ex_valid_o & !ex_ready_i, all ex_* payload outputs SHALL remain stable.
REQ-032 Payload SHALL be copied bit-exact; no arithmetic or width change.
REQ-033 stall_cnt_o SHALL increment by 1 each cycle ex_valid_o & !ex_ready_i, saturating at 16'hFFFF (no wrap).
REQ-034 clr_cnt_i SHALL zero stall_cnt_o next cycle, taking priority over increment; flush_i SHALL NOT affect the counter.

Reset
REQ-035 rst_ni low SHALL immediately force EMPTY, ex_valid_o = 0, id_ready_o = 1, all payload outputs and SKID slot = 0, stall_cnt_o = 0.
REQ-036 Reset asserted mid-transfer SHALL discard both slots; first accept after deassertion behaves as from EMPTY.

Verification
REQ-037 Streaming: id_valid_i=1 with PCs 0x0,0x4,0x8, ex_ready_i=1 -> ex_pc_o 0x0,0x4,0x8 on consecutive cycles, one-cycle latency, id_ready_o always 1.
REQ-038 Back-pressure: ex_ready_i=0 while PCs 0x10,0x14 offered -> 0x10 held on ex_pc_o, 0x14 in SKID, id_ready_o=0; ex_ready_i=1 -> 0x10 then 0x14 delivered, id_ready_o returns to 1.
REQ-039 Flush in SKID with id_valid_i=1 -> next cycle ex_valid_o=0, id_ready_o=1, incoming instruction never appears.
REQ-040 Counter: ex_valid_o=1, ex_ready_i=0 for 5 cycles -> stall_cnt_o=5; preload near 16'hFFFF -> holds 16'hFFFF; clr_cnt_i with stall active -> 0.
REQ-041 Async reset: assert rst_ni=0 between clock edges in SKID -> outputs zero immediately, before next edge.
REQ-042 Payload integrity: id_imm_i=32'hFFFF_F800, id_ctrl_i=8'hA5, rd=5'd31 -> identical values on ex_imm_o, ex_ctrl_o, ex_rd_addr_o.
